waveform_capture: RTL and testbench
===================================

Name: waveform_capture

Overview:
- Avalon-MM slave peripheral that samples a 10-bit waveform bus (e.g. oData_sin from the sine generator) at a programmable rate.
- Buffers samples in an on-chip FIFO that the CPU drains over Avalon.
- Raises a level-sensitive IRQ on a fill threshold or on overflow.
- Completes the generate/capture loop for on-chip loopback test of the waveform path.

Parameters:
- DEPTH, 64, FIFO depth in samples; power of two, 4..256.
- LW, 9, width of level fields; must hold DEPTH, i.e. log2(DEPTH)+1.

Ports:
- Clk  in  1  system clock; single clock domain.
- ResetN  in  1  asynchronous active-low reset.
- ChipSelect  in  1  Avalon slave select.
- Write  in  1  Avalon write strobe.
- Read  in  1  Avalon read strobe; one cycle per access, 0 wait states.
- Address  in  2  register index.
- WriteData  in  32  write data.
- ReadData  out  32  read data, combinational from Address (read latency 0).
- iData_sample  in  10  waveform input; synchronous to Clk.
- irq  out  1  interrupt request, level-sensitive.

Behaviour:
- Register map:
  - 0 CTRL R/W: [0] run; [1] irq_en; [2] flush (write-only, self-clearing, reads 0).
  - 1 CFG R/W: [15:0] div; [23:16] thr.
  - 2 STATUS R: [LW-1:0] level; [16] empty; [17] full; [18] ovf (sticky); [19] irq. Writing 1 to bit 18 clears ovf.
  - 3 DATA R: [9:0] oldest sample; [31] valid. A read pops the FIFO.
  - Unused bits read 0. Writes to STATUS bits other than 18 and all writes to DATA are ignored.
- Reset values:
  - CTRL=0, CFG=0, FIFO empty, ovf=0, divider count=0, irq=0.
  - ReadData follows Address; reset value is whatever the CSR mux yields.
- Sample tick:
  - Counter cnt[15:0] counts only when run=1.
  - tick=1 when cnt==div; cnt then wraps to 0, otherwise cnt increments.
  - div=0 gives a tick every clock. div=N gives a tick every N+1 clocks.
  - run=0 holds cnt at 0.
  - Any write to CFG clears cnt to 0 that cycle, with no tick.
  - First tick after run rises occurs div clocks after the CTRL write cycle.
- Push: on tick, iData_sample as seen that cycle is written to the FIFO, visible in level the next cycle.
- Pop: ChipSelect&Read&Address==3.
  - FIFO not empty: ReadData={1'b1,21'b0,head}; head advances at the clock edge.
  - FIFO empty: ReadData=0 and no pointer change.
- Simultaneous events:
  - Push+pop when full: both succeed, level unchanged, ovf unchanged.
  - Push when full without pop: sample dropped, ovf set to 1.
  - Push+pop when empty: pop returns 0/invalid; push stored, level=1 next cycle.
  - Flush: pointers and level go to 0 next cycle and any same-cycle push is discarded. ovf is not affected.
  - ovf set and clear-write in the same cycle: set wins.
- irq = irq_en & ((thr!=0 & level>=thr) | ovf), registered, i.e. updates 1 cycle after its inputs. Writing irq_en=0 deasserts irq the next cycle.
- level saturates at DEPTH; thr greater than DEPTH never triggers.
- Reset mid-operation: all state returns to reset values asynchronously and FIFO contents are discarded.

Decomposition:
- Shared package waveform_capture_pkg:
  - address constants ADDR_CTRL/CFG/STATUS/DATA;
  - bit positions CTRL_RUN, CTRL_IRQEN, CTRL_FLUSH, ST_EMPTY, ST_FULL, ST_OVF, ST_IRQ, DATA_VALID;
  - SAMPLE_W=10.
- Sub-module capture_fifo:
  - parameterized synchronous FIFO with push, pop, flush, full, empty, level, head;
  - pointer width log2(DEPTH)+1 for full/empty disambiguation.
- CSR decode, divider and IRQ logic stay in waveform_capture.

Test Plan:
- Reset, then read all four addresses -> 0, except STATUS=0x00010000 (empty=1); irq=0.
- CFG.div=3, CTRL=1, ramp input 0,1,2,... -> ticks every 4 clocks; after 5 ticks level=5; five DATA reads return 0x800000xx with values matching input at each tick, then 0x00000000.
- div=0, run for DEPTH+3 clocks without reads -> full=1, ovf=1, level=DEPTH; write STATUS=0x40000 -> ovf=0; first DATA read returns first captured sample.
- thr=4, irq_en=1 -> irq rises 1 cycle after level reaches 4; one DATA pop (level=3) -> irq falls next cycle.
- FIFO full with pop and tick in the same cycle -> level stays DEPTH, ovf=0; then flush during a tick -> level=0, empty=1, ovf preserved.
- ResetN low mid-capture with level=10 -> immediately level=0, CTRL=0, irq=0; capture resumes only after run is rewritten.

Source files
------------

// File: rtl/waveform_capture_pkg.sv
// ============================================================================
// Module  : waveform_capture_pkg
// Brief   : Register addresses, bit positions and sample width shared by the
//           waveform capture peripheral.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package waveform_capture_pkg;

    localparam int SAMPLE_W = 10;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_CFG    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_DATA   = 2'd3;

    localparam int CTRL_RUN   = 0;
    localparam int CTRL_IRQEN = 1;
    localparam int CTRL_FLUSH = 2;

    localparam int ST_EMPTY   = 16;
    localparam int ST_FULL    = 17;
    localparam int ST_OVF     = 18;
    localparam int ST_IRQ     = 19;

    localparam int DATA_VALID = 31;

endpackage

`default_nettype wire

// File: rtl/waveform_capture_if.sv
// ============================================================================
// Module  : waveform_capture_if
// Brief   : Avalon-MM slave bus bundle (zero wait states, read latency 0).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface waveform_capture_if;
    logic        ChipSelect;
    logic        Write;
    logic        Read;
    logic [1:0]  Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output ChipSelect, Write, Read, Address, WriteData,
        input  ReadData
    );

    modport slave (
        input  ChipSelect, Write, Read, Address, WriteData,
        output ReadData
    );
endinterface

`default_nettype wire

// File: rtl/waveform_capture_fifo.sv
// ============================================================================
// Module  : capture_fifo
// Brief   : Synchronous FIFO with flush; pointers carry one extra wrap bit so
//           full and empty are distinguishable.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module capture_fifo #(
    parameter int DEPTH = 64,
    parameter int LW    = 9,
    parameter int W     = 10
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          i_push,
    input  wire logic          i_pop,
    input  wire logic          i_flush,
    input  wire logic [W-1:0]  i_data,
    output logic               o_full,
    output logic               o_empty,
    output logic [LW-1:0]      o_level,
    output logic [W-1:0]       o_head
);

    localparam int            AW     = $clog2(DEPTH);
    localparam logic [LW-1:0] c_FULL = LW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [LW-1:0] r_wr_ptr;
    logic [LW-1:0] r_rd_ptr;
    logic [LW-1:0] w_level;
    logic          w_full;
    logic          w_empty;
    logic          w_pop_ok;
    logic          w_push_ok;

    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_level == c_FULL);
    assign w_empty   = (w_level == '0);
    assign w_pop_ok  = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts it.
    assign w_push_ok = i_push & (~w_full | w_pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + LW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = w_level;
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/waveform_capture.sv
// ============================================================================
// Module  : waveform_capture
// Brief   : Avalon-MM peripheral sampling a waveform bus at a programmable
//           rate into a FIFO, with threshold/overflow interrupt.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module waveform_capture
    import waveform_capture_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int LW    = 9
) (
    input  wire logic                Clk,
    input  wire logic                ResetN,
    waveform_capture_if.slave        avs,
    input  wire logic [SAMPLE_W-1:0] iData_sample,
    output logic                     irq
);

    logic          r_run;
    logic          r_irq_en;
    logic [15:0]   r_div;
    logic [7:0]    r_thr;
    logic [15:0]   r_cnt;
    logic          r_ovf;
    logic          r_irq;

    logic          w_wr;
    logic          w_wr_ctrl;
    logic          w_wr_cfg;
    logic          w_wr_status;
    logic          w_pop;
    logic          w_flush;
    logic          w_tick;
    logic          w_ovf_set;
    logic          w_irq_en_nxt;
    logic          w_thr_hit;
    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_level;
    logic [SAMPLE_W-1:0] w_head;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_wr        = avs.ChipSelect & avs.Write;
    assign w_wr_ctrl   = w_wr & (avs.Address == ADDR_CTRL);
    assign w_wr_cfg    = w_wr & (avs.Address == ADDR_CFG);
    assign w_wr_status = w_wr & (avs.Address == ADDR_STATUS);
    assign w_pop       = avs.ChipSelect & avs.Read & (avs.Address == ADDR_DATA);
    assign w_flush     = w_wr_ctrl & avs.WriteData[CTRL_FLUSH];

    // A CFG write restarts the sampling period and suppresses that cycle's tick.
    assign w_tick    = r_run & ~w_wr_cfg & (r_cnt == r_div);
    assign w_ovf_set = w_tick & w_full & ~w_pop & ~w_flush;

    assign w_irq_en_nxt = w_wr_ctrl ? avs.WriteData[CTRL_IRQEN] : r_irq_en;
    assign w_thr_hit    = (r_thr != 8'd0) && (16'(w_level) >= 16'(r_thr));

    capture_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW),
        .W     (SAMPLE_W)
    ) u_fifo (
        .clk     (Clk),
        .rst_n   (ResetN),
        .i_push  (w_tick),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (iData_sample),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level),
        .o_head  (w_head)
    );

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_run    <= 1'b0;
            r_irq_en <= 1'b0;
            r_div    <= '0;
            r_thr    <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_run    <= avs.WriteData[CTRL_RUN];
                r_irq_en <= avs.WriteData[CTRL_IRQEN];
            end
            if (w_wr_cfg) begin
                r_div <= avs.WriteData[15:0];
                r_thr <= avs.WriteData[23:16];
            end
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_cnt <= '0;
        end else if (w_wr_cfg || !r_run || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_ovf <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && avs.WriteData[ST_OVF]) begin
                r_ovf <= 1'b0;
            end
            r_irq <= w_irq_en_nxt & (w_thr_hit | r_ovf);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (avs.Address)
            ADDR_CTRL: begin
                w_rdata[CTRL_RUN]   = r_run;
                w_rdata[CTRL_IRQEN] = r_irq_en;
            end
            ADDR_CFG: begin
                w_rdata[23:0] = {r_thr, r_div};
            end
            ADDR_STATUS: begin
                w_rdata[LW-1:0] = w_level;
                w_rdata[ST_EMPTY] = w_empty;
                w_rdata[ST_FULL]  = w_full;
                w_rdata[ST_OVF]   = r_ovf;
                w_rdata[ST_IRQ]   = r_irq;
            end
            ADDR_DATA: begin
                if (!w_empty) begin
                    w_rdata[DATA_VALID]     = 1'b1;
                    w_rdata[SAMPLE_W-1:0] = w_head;
                end
            end
            default: w_rdata = '0;
        endcase
    end

    assign avs.ReadData = w_rdata;
    assign irq          = r_irq;
    assign w_unused     = ^avs.WriteData[31:24];

endmodule

`default_nettype wire

// File: tb/tb_waveform_capture.sv
// ============================================================================
// Module  : tb_waveform_capture
// Brief   : Directed + randomized bench with a queue-based reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_waveform_capture;

    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic       Clk = 1'b0;
    logic       ResetN;
    logic [9:0] iData_sample;
    logic       irq;

    waveform_capture_if bus();

    waveform_capture #(.DEPTH(DEPTH), .LW(LW)) dut (
        .Clk          (Clk),
        .ResetN       (ResetN),
        .avs          (bus.slave),
        .iData_sample (iData_sample),
        .irq          (irq)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as a queue, sample period as a phase count.
    int          q[$];
    bit          m_run, m_irqen, m_ovf, m_irq;
    logic [15:0] m_div;
    logic [7:0]  m_thr;
    int          m_phase;

    task automatic model_reset();
        q.delete();
        m_run = 0; m_irqen = 0; m_ovf = 0; m_irq = 0;
        m_div = '0; m_thr = '0; m_phase = 0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r = {30'd0, m_irqen, m_run};
            2'd1: r = {8'd0, m_thr, m_div};
            2'd2: begin
                r = 32'(q.size());
                r[16] = (q.size() == 0);
                r[17] = (q.size() == DEPTH);
                r[18] = m_ovf;
                r[19] = m_irq;
            end
            default: if (q.size() != 0) r = {1'b1, 21'd0, 10'(q[0])};
        endcase
        return r;
    endfunction

    task automatic model_step();
        bit wr, rd, wctrl, wcfg, wst, rdd, pop, flush, tick, en_n, hit, ovf_set;
        wr    = bus.ChipSelect && bus.Write;
        rd    = bus.ChipSelect && bus.Read;
        wctrl = wr && bus.Address == 2'd0;
        wcfg  = wr && bus.Address == 2'd1;
        wst   = wr && bus.Address == 2'd2;
        rdd   = rd && bus.Address == 2'd3;
        pop   = rdd && q.size() != 0;
        flush = wctrl && bus.WriteData[2];
        tick  = m_run && !wcfg && ((m_phase % (int'(m_div) + 1)) == int'(m_div));
        en_n  = wctrl ? bus.WriteData[1] : m_irqen;
        hit   = (m_thr != 0) && (q.size() >= int'(m_thr));
        ovf_set = tick && q.size() == DEPTH && !rdd && !flush;
        m_irq = en_n && (hit || m_ovf);
        if (ovf_set) m_ovf = 1;
        else if (wst && bus.WriteData[18]) m_ovf = 0;
        if (flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (tick && q.size() < DEPTH) q.push_back(int'(iData_sample));
        end
        m_phase = (wcfg || !m_run) ? 0 : m_phase + 1;
        if (wctrl) begin m_run = bus.WriteData[0]; m_irqen = bus.WriteData[1]; end
        if (wcfg) begin m_div = bus.WriteData[15:0]; m_thr = bus.WriteData[23:16]; end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One clock: inputs already driven at the falling edge.
    task automatic cycle(input string tag);
        iData_sample = 10'($urandom);
        #1;
        chk({tag, "/rdata"}, bus.ReadData, exp_rd(bus.Address));
        chk({tag, "/irq"}, {31'd0, irq}, {31'd0, m_irq});
        if (ResetN) model_step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic op(input bit cs, input bit rd, input bit wr, input logic [1:0] a,
                      input logic [31:0] d, input string tag);
        bus.ChipSelect = cs; bus.Read = rd; bus.Write = wr;
        bus.Address = a; bus.WriteData = d;
        cycle(tag);
    endtask

    task automatic idle(input string tag);
        op(0, 0, 0, 2'd2, 32'd0, tag);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input string tag);
        op(1, 0, 1, a, d, tag);
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
        bus.ChipSelect = 1; bus.Read = 1; bus.Write = 0;
        bus.Address = a; bus.WriteData = 0;
        #1 chk(tag, bus.ReadData, exp);
        cycle(tag);
    endtask

    task automatic wait_lvl(input int n, input string tag);
        for (int k = 0; k < 500 && q.size() != n; k++) idle(tag);
        chk({tag, "/wait"}, 32'(q.size()), 32'(n));
    endtask

    initial begin
        logic [31:0] d;
        int          sel;
        model_reset();
        ResetN = 1'b0;
        bus.ChipSelect = 0; bus.Read = 0; bus.Write = 0;
        bus.Address = 0; bus.WriteData = 0; iData_sample = 0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        ResetN = 1'b1;

        // Reset state
        rd_chk(2'd0, 32'h0, "rst_ctrl");
        rd_chk(2'd1, 32'h0, "rst_cfg");
        rd_chk(2'd2, 32'h0001_0000, "rst_status");
        rd_chk(2'd3, 32'h0, "rst_data");
        chk("rst_irq", {31'd0, irq}, 32'd0);

        // Capture every 4 clocks, then drain
        wr(2'd1, 32'd3, "cfg_div3");
        wr(2'd0, 32'd1, "run");
        wait_lvl(5, "ramp");
        wr(2'd0, 32'd0, "stop");
        rd_chk(2'd2, 32'h0000_0005, "ramp_level");
        for (int i = 0; i < 5; i++) rd_chk(2'd3, exp_rd(2'd3) | 32'h8000_0000, "ramp_pop");
        rd_chk(2'd3, 32'h0, "ramp_empty");

        // Overflow with div=0
        wr(2'd1, 32'd0, "cfg_div0");
        wr(2'd0, 32'd1, "run_ovf");
        for (int i = 0; i < DEPTH + 3; i++) idle("fill");
        wr(2'd0, 32'd0, "stop_ovf");
        rd_chk(2'd2, 32'h0006_0000 | DEPTH, "ovf_status");
        wr(2'd2, 32'h0004_0000, "ovf_clr");
        rd_chk(2'd2, 32'h0002_0000 | DEPTH, "ovf_cleared");
        rd_chk(2'd3, exp_rd(2'd3), "ovf_first");

        // Threshold interrupt
        wr(2'd0, 32'd4, "flush1");
        wr(2'd1, 32'h0004_0001, "cfg_thr4");
        wr(2'd0, 32'd3, "run_irq");
        wait_lvl(4, "thr");
        chk("irq_pre", {31'd0, irq}, 32'd0);
        wr(2'd0, 32'd2, "stop_thr");
        chk("irq_rise", {31'd0, irq}, 32'd1);
        rd_chk(2'd3, exp_rd(2'd3), "thr_pop");
        idle("thr_idle");
        chk("irq_fall", {31'd0, irq}, 32'd0);
        wr(2'd0, 32'd0, "irq_off");

        // Full with simultaneous push/pop, then flush during a tick
        wr(2'd0, 32'd4, "flush2");
        wr(2'd1, 32'd0, "cfg_full");
        wr(2'd0, 32'd1, "run_full");
        wait_lvl(DEPTH, "full");
        rd_chk(2'd3, exp_rd(2'd3), "full_pushpop");
        rd_chk(2'd2, 32'h0002_0000 | DEPTH, "full_keep");
        wr(2'd0, 32'd5, "flush_tick");
        rd_chk(2'd2, 32'h0005_0000, "flush_status");

        // Asynchronous reset mid-capture
        wr(2'd2, 32'h0004_0000, "clr2");
        wr(2'd0, 32'd4, "flush3");
        wr(2'd0, 32'd1, "run_rst");
        wait_lvl(10, "rst_lvl");
        bus.ChipSelect = 0; bus.Read = 0; bus.Write = 0; bus.Address = 2'd2;
        ResetN = 1'b0;
        #1;
        chk("arst_status", bus.ReadData, 32'h0001_0000);
        chk("arst_irq", {31'd0, irq}, 32'd0);
        bus.Address = 2'd0;
        #1 chk("arst_ctrl", bus.ReadData, 32'h0);
        model_reset();
        @(negedge Clk);
        idle("in_rst");
        ResetN = 1'b1;
        repeat (5) idle("post_rst");
        rd_chk(2'd2, 32'h0001_0000, "no_capture");
        wr(2'd0, 32'd1, "rerun");
        repeat (3) idle("resume");
        rd_chk(2'd2, 32'h0000_0003, "resumed");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: wr(2'd0, 32'($urandom_range(0, 7)) & ((($urandom_range(0, 3)) == 0) ? 32'h7 : 32'h3), "r_ctrl");
                1: begin
                    d = {8'($urandom), 8'($urandom_range(0, DEPTH + 2)), 16'($urandom_range(0, 5))};
                    wr(2'd1, d, "r_cfg");
                end
                2: wr(2'd2, $urandom, "r_status");
                3: wr(2'd3, $urandom, "r_data_wr");
                4, 5: op(1, 1, 0, 2'd3, 32'd0, "r_pop");
                6: op(1, 1, 0, 2'($urandom_range(0, 2)), 32'd0, "r_read");
                default: op(0, 0, 0, 2'($urandom_range(0, 3)), 32'd0, "r_idle");
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
